// File: rtl/digit_seq_player.sv
`default_nettype none
// ============================================================================
// Module   : digit_seq_player
// Purpose  : Programmable digit-table player. Steps through up to DEPTH stored
//            digits, either upward or downward, once or looping. The current
//            digit and index are presented from registers.
// Revision : 1.0 - initial release
// ============================================================================
module digit_seq_player #(
    parameter int DIGIT_W = 4,
    parameter int DEPTH   = 8,
    parameter int IDX_W   = 3
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [DIGIT_W-1:0] wr_data,
    input  logic [IDX_W-1:0]   len,
    input  logic               dir,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    output logic [DIGIT_W-1:0] out,
    output logic [IDX_W-1:0]   idx,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    // Table address width: enough bits for 0..DEPTH-1 only.
    localparam int               AW         = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   DEPTH_WIDE = (IDX_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx_nx;
    logic [IDX_W-1:0]   len_q, len_nx;
    logic               dir_q, dir_nx;
    logic               loop_q, loop_nx;
    logic               wrap_nx;
    logic               done_nx;
    logic [IDX_W-1:0]   len_clamped;
    logic               at_end;
    logic               wr_hit;

    logic [DIGIT_W-1:0] table_q [DEPTH];

    // Length requests beyond the table are clamped to its last entry.
    assign len_clamped = (len > LAST_IDX) ? LAST_IDX : len;

    // End position depends on the direction captured at start.
    assign at_end = dir_q ? (idx == '0) : (idx == len_q);

    // Writes to addresses outside the table are dropped.
    assign wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_WIDE);

    // idx never exceeds len_q <= DEPTH-1, so the truncated index is exact.
    assign out  = table_q[idx[AW-1:0]];
    assign busy = (state == PLAY);

    // Digit table storage, cleared by reset and writable in any state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_hit) begin
            table_q[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Playback state, index and captured start parameters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            idx    <= '0;
            len_q  <= '0;
            dir_q  <= 1'b0;
            loop_q <= 1'b0;
            wrap   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            len_q  <= len_nx;
            dir_q  <= dir_nx;
            loop_q <= loop_nx;
            wrap   <= wrap_nx;
            done   <= done_nx;
        end
    end

    // Command decode with priority stop > start > step.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        len_nx   = len_q;
        dir_nx   = dir_q;
        loop_nx  = loop_q;
        wrap_nx  = 1'b0;
        done_nx  = 1'b0;

        if (stop) begin
            // Abort leaves idx where it is and raises no pulses.
            state_nx = IDLE;
        end else if (start) begin
            len_nx   = len_clamped;
            dir_nx   = dir;
            loop_nx  = loop;
            idx_nx   = dir ? len_clamped : '0;
            state_nx = PLAY;
        end else if (step && (state == PLAY)) begin
            if (!at_end) begin
                idx_nx = dir_q ? (idx - IDX_W'(1)) : (idx + IDX_W'(1));
            end else if (loop_q) begin
                idx_nx  = dir_q ? len_q : '0;
                wrap_nx = 1'b1;
            end else begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_seq_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_seq_player
// Purpose  : Self-checking bench for digit_seq_player against a behavioural
//            reference model (DEPTH=8, IDX_W=4, DIGIT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_seq_player;

    localparam int DIGIT_W = 4;
    localparam int DEPTH   = 8;
    localparam int IDX_W   = 4;

    logic               CLK = 1'b0;
    logic               RST_N = 1'b0;
    logic               wr_en = 1'b0;
    logic [IDX_W-1:0]   wr_addr = '0;
    logic [DIGIT_W-1:0] wr_data = '0;
    logic [IDX_W-1:0]   len = '0;
    logic               dir = 1'b0;
    logic               loop = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               step = 1'b0;
    logic [DIGIT_W-1:0] out;
    logic [IDX_W-1:0]   idx;
    logic               busy;
    logic               wrap;
    logic               done;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_mem [DEPTH];
    int m_idx, m_len;
    bit m_dir, m_loop, m_play, m_wrap, m_done;

    digit_seq_player #(
        .DIGIT_W (DIGIT_W),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .len     (len),
        .dir     (dir),
        .loop    (loop),
        .start   (start),
        .stop    (stop),
        .step    (step),
        .out     (out),
        .idx     (idx),
        .busy    (busy),
        .wrap    (wrap),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_idx = 0; m_len = 0; m_dir = 0; m_loop = 0;
        m_play = 0; m_wrap = 0; m_done = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".idx"},  int'(idx),  m_idx);
        check({tag, ".out"},  int'(out),  m_mem[m_idx]);
        check({tag, ".busy"}, int'(busy), int'(m_play));
        check({tag, ".wrap"}, int'(wrap), int'(m_wrap));
        check({tag, ".done"}, int'(done), int'(m_done));
    endtask

    // One clock: drive inputs at negedge, let the edge happen, update the
    // model from the playback rules, then compare at the next negedge.
    task automatic tick(input string tag, input bit we, input int wa, input int wd,
                        input int ln, input bit d, input bit lp,
                        input bit st, input bit sp, input bit stp);
        wr_en = we; wr_addr = IDX_W'(wa); wr_data = DIGIT_W'(wd);
        len = IDX_W'(ln); dir = d; loop = lp;
        start = st; stop = sp; step = stp;
        @(posedge CLK);
        m_wrap = 0;
        m_done = 0;
        if (sp) begin
            m_play = 0;
        end else if (st) begin
            m_len  = (ln > DEPTH - 1) ? DEPTH - 1 : ln;
            m_dir  = d;
            m_loop = lp;
            m_idx  = d ? m_len : 0;
            m_play = 1;
        end else if (stp && m_play) begin
            if (!m_dir && m_idx < m_len)      m_idx = m_idx + 1;
            else if (m_dir && m_idx > 0)      m_idx = m_idx - 1;
            else if (m_loop) begin
                m_idx  = m_dir ? m_len : 0;
                m_wrap = 1;
            end else begin
                m_play = 0;
                m_done = 1;
            end
        end
        if (we && wa < DEPTH) m_mem[wa] = wd;
        @(negedge CLK);
        check_all(tag);
    endtask

    task automatic idle_tick(input string tag);
        tick(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int bday [8] = '{1, 9, 9, 8, 0, 3, 1, 5};
        model_reset();
        #12;
        check_all("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        check_all("reset_release");

        // step while idle must not move idx
        tick("idle_step", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // load the table and play it once upward
        for (int i = 0; i < 8; i++) tick("load", 1, i, bday[i], 0, 0, 0, 0, 0, 0);
        tick("once_start", 0, 0, 0, 7, 0, 0, 1, 0, 0);
        steps("once_up", 8);
        check("once_end_idx", int'(idx), 7);
        idle_tick("once_after");

        // looping downward over the first four entries
        tick("loopdn_start", 0, 0, 0, 3, 1, 1, 1, 0, 0);
        check("loopdn_first_out", int'(out), 8);
        steps("loop_down", 9);

        // clamp of an oversize length, then len=0 corner cases
        tick("clamp_start", 0, 0, 0, 12, 1, 0, 1, 0, 0);
        check("clamp_idx", int'(idx), 7);
        tick("len0_loop", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        steps("len0_loop_step", 3);
        tick("len0_once", 0, 0, 0, 0, 1, 0, 1, 0, 0);
        steps("len0_once_step", 2);

        // command priority
        tick("prio_start", 0, 0, 0, 7, 0, 1, 1, 0, 0);
        steps("prio_run", 2);
        tick("prio_all", 0, 0, 0, 5, 1, 0, 1, 1, 1);
        tick("prio_start2", 0, 0, 0, 5, 0, 0, 1, 0, 0);
        steps("prio_run2", 3);
        tick("prio_start_step", 0, 0, 0, 6, 1, 1, 1, 0, 1);

        // live write to the displayed entry and an out-of-range write
        tick("live_start", 0, 0, 0, 7, 0, 1, 1, 0, 0);
        steps("live_run", 2);
        tick("live_write", 1, 2, 6, 0, 0, 0, 0, 0, 0);
        check("live_out", int'(out), 6);
        tick("oob_write", 1, 9, 15, 0, 0, 0, 0, 0, 0);
        tick("write_step", 1, 2, 4, 0, 0, 0, 0, 0, 1);
        steps("live_more", 2);

        // asynchronous reset in the middle of playback
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge CLK);
        RST_N = 1'b1;
        idle_tick("post_rst");

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            tick("rand",
                 ($urandom_range(0, 99) < 15),
                 $urandom_range(0, 15),
                 $urandom_range(0, 15),
                 $urandom_range(0, 15),
                 $urandom_range(0, 1),
                 $urandom_range(0, 1),
                 (r < 8),
                 (r >= 8 && r < 12),
                 ($urandom_range(0, 99) < 65));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
